// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the mMIPS pipeline.
// It holds the PC, drives the instruction memory and loads the IF/ID register
// under the control of the hazard unit. A one-entry hold buffer catches a word
// that is fetched while IF/ID is frozen (a branch-hazard prefetch). That word
// is then delivered later and is never fetched a second time.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   PCWrite          PC may advance
//   IFIDWrite        IF/ID may load
//   imem_en          memory request permitted
//   pipe_en          global pipeline enable (0 freezes PC, IF/ID and hold)
//   branch_taken     redirect to branch_target and squash IF/ID
//   branch_target    redirect address (forced to word alignment)
//   imem_addr        current PC, to instruction memory
//   imem_req         fetch request
//   imem_rdata       instruction at imem_addr; valid when imem_req & ~imem_wait
//   imem_wait        memory not ready this cycle
//   Instr            IF/ID instruction
//   ifid_pc4         PC+4 of Instr
//   ifid_valid       Instr is a real fetched instruction, not a bubble
//   fetch_count      completed fetches, saturating
//   stall_count      stalled cycles, saturating
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             IFIDWrite,
  input  logic             imem_en,
  input  logic             pipe_en,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_wait,
  output logic [31:0]      Instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic { EMPTY, HELD } hold_state_t;

  // Source of the value loaded into IF/ID on an enabled edge.
  typedef enum logic [1:0] { SRC_NOP, SRC_MEM, SRC_HOLD } ifid_src_t;

  hold_state_t state, state_next;
  ifid_src_t   ifid_src;

  logic [31:0] pc, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] hold_instr, hold_pc4;
  logic        fetch_fire;
  logic        ifid_load;
  logic        hold_load;
  logic        squash;
  logic        fetch_inc;
  logic        stall_inc;

  assign imem_addr = pc;
  assign imem_req  = imem_en & pipe_en & ~rst;
  assign pc_plus4  = pc + 32'd4;   // wraps modulo 2^32

  // While a word is held, a new fetch is only allowed if IF/ID drains the
  // buffer on the same edge; otherwise the buffer would overflow.
  assign fetch_fire = imem_req & ~imem_wait & PCWrite & ((state == EMPTY) | IFIDWrite);

  assign squash    = pipe_en & branch_taken;
  assign fetch_inc = fetch_fire & ~squash;
  assign stall_inc = ~pipe_en | ~IFIDWrite;

  // Next-state and datapath-enable logic.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    pc_next    = pc;
    ifid_load  = 1'b0;
    ifid_src   = SRC_NOP;
    hold_load  = 1'b0;

    if (squash) begin
      pc_next    = branch_target & 32'hFFFF_FFFC;
      ifid_load  = 1'b1;
      ifid_src   = SRC_NOP;
      state_next = EMPTY;
    end else if (pipe_en) begin
      if (fetch_fire) pc_next = pc_plus4;

      unique case (state)
        EMPTY: begin
          if (fetch_fire && IFIDWrite) begin
            ifid_load = 1'b1;
            ifid_src  = SRC_MEM;
          end else if (fetch_fire) begin
            hold_load  = 1'b1;
            state_next = HELD;
          end else if (IFIDWrite) begin
            ifid_load = 1'b1;
            ifid_src  = SRC_NOP;
          end
        end
        HELD: begin
          if (IFIDWrite) begin
            ifid_load = 1'b1;
            ifid_src  = SRC_HOLD;
            if (fetch_fire) hold_load  = 1'b1;
            else            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // PC, hold state, IF/ID register and counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update from the same pre-edge values.
    if (rst) begin
      pc          <= RESET_PC;
      state       <= EMPTY;
      Instr       <= NOP_INSTR;
      ifid_pc4    <= 32'd0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      pc    <= pc_next;
      state <= state_next;

      if (ifid_load) begin
        unique case (ifid_src)
          SRC_MEM: begin
            Instr      <= imem_rdata;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
          end
          SRC_HOLD: begin
            Instr      <= hold_instr;
            ifid_pc4   <= hold_pc4;
            ifid_valid <= 1'b1;
          end
          default: begin
            // Bubble: ifid_pc4 keeps its previous value.
            Instr      <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end
        endcase
      end

      if (fetch_inc && (fetch_count != '1)) fetch_count <= fetch_count + CNT_W'(1);
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

  // NOTE: the hold payload has no reset; it is only read in state HELD, and
  // it is always written on the edge that enters HELD.
  always_ff @(posedge clk) begin
    if (!rst && hold_load) begin
      hold_instr <= imem_rdata;
      hold_pc4   <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Scoreboard bench for if_fetch_stage. The driver applies inputs on the
// falling edge. It then advances a reference model in which the hold buffer
// is a queue. Every fetched word is pushed; an enabled IF/ID edge pops a word,
// or loads a bubble when the queue is empty. The driver pushes the expected
// post-edge outputs into a scoreboard queue. A monitor pops that queue after
// each rising edge and compares the entry with the DUT.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          CNT_W     = 16;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             PCWrite = 1'b0, IFIDWrite = 1'b0, imem_en = 1'b0, pipe_en = 1'b0;
  logic             branch_taken = 1'b0;
  logic [31:0]      branch_target = 32'd0;
  logic [31:0]      imem_addr;
  logic             imem_req;
  logic [31:0]      imem_rdata;
  logic             imem_wait = 1'b0;
  logic [31:0]      Instr;
  logic [31:0]      ifid_pc4;
  logic             ifid_valid;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .imem_en      (imem_en),
    .pipe_en      (pipe_en),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_rdata   (imem_rdata),
    .imem_wait    (imem_wait),
    .Instr        (Instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
  );

  // Instruction memory contents: a few fixed words, and a hash everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0007;
      32'h0000_0010: return 32'hAAAA_0000;
      default:       return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
    endcase
  endfunction

  // The memory presents garbage whenever the data is not valid.
  always_comb imem_rdata = (imem_req && !imem_wait) ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } entry_t;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    int          fc;
    int          sc;
    logic        chk;
  } exp_t;

  entry_t      m_hold[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          m_fc;
  int          m_sc;
  exp_t        exp_q[$];
  logic        chk_en = 1'b1;

  // Applies one cycle of inputs and records the expected post-edge outputs.
  task automatic step(input logic r, input logic pcw, input logic ifw, input logic en,
                      input logic pe, input logic bt, input logic [31:0] tgt,
                      input logic wt);
    logic fire;
    exp_t e;
    @(negedge clk);
    rst = r; PCWrite = pcw; IFIDWrite = ifw; imem_en = en; pipe_en = pe;
    branch_taken = bt; branch_target = tgt; imem_wait = wt;

    if (r) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
      m_fc = 0; m_sc = 0;
      m_hold.delete();
    end else begin
      fire = en && pe && !wt && pcw && (m_hold.size() == 0 || ifw);
      if (!pe || !ifw) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
      if (pe && bt) begin
        m_pc = {tgt[31:2], 2'b00};
        m_instr = NOP_INSTR; m_valid = 1'b0;
        m_hold.delete();
      end else if (pe) begin
        if (fire) begin
          m_hold.push_back('{instr: mem_word(m_pc), pc4: m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
          m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
        end
        if (ifw) begin
          if (m_hold.size() > 0) begin
            entry_t w;
            w = m_hold.pop_front();
            m_instr = w.instr; m_pc4 = w.pc4; m_valid = 1'b1;
          end else begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
          end
        end
      end
    end

    e.pc = m_pc; e.req = en && pe && !r; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.fc = m_fc; e.sc = m_sc; e.chk = chk_en;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic pcw, input logic ifw, input logic wt);
    step(1'b0, pcw, ifw, 1'b1, 1'b1, 1'b0, 32'd0, wt);
  endtask

  task automatic branch(input logic [31:0] tgt);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, tgt, 1'b0);
  endtask

  // Lets the next rising edge happen so that direct checks see its result.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) begin
          check("imem_addr",   imem_addr,          e.pc);
          check("imem_req",    {31'd0, imem_req},   {31'd0, e.req});
          check("Instr",       Instr,               e.instr);
          check("ifid_pc4",    ifid_pc4,            e.pc4);
          check("ifid_valid",  {31'd0, ifid_valid}, {31'd0, e.valid});
          check("fetch_count", 32'(fetch_count),    32'(e.fc));
          check("stall_count", 32'(stall_count),    32'(e.sc));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Straight-line fetch of the first two words
    run(1'b1, 1'b1, 1'b0);
    run(1'b1, 1'b1, 1'b0);
    settle();
    check("tp_instr_cycle2", Instr, 32'h2009_0007);
    check("tp_pc4_cycle2", ifid_pc4, 32'h0000_0008);
    check("tp_fc_cycle2", 32'(fetch_count), 32'd2);

    // Memory wait for three cycles at pc=0x8, then the fetch completes
    repeat (3) run(1'b1, 1'b1, 1'b1);
    run(1'b1, 1'b1, 1'b0);
    settle();
    check("wait_pc_after", imem_addr, 32'h0000_000C);
    check("wait_stall_count", 32'(stall_count), 32'd0);

    // pc=0xC -> 0x10, then prefetch at 0x10 with IF/ID frozen
    run(1'b1, 1'b1, 1'b0);
    run(1'b1, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0);
    settle();
    check("held_instr_delivered", Instr, 32'hAAAA_0000);
    check("held_pc4_delivered", ifid_pc4, 32'h0000_0014);

    // Prefetch into the hold buffer, then a taken branch discards it
    run(1'b1, 1'b0, 1'b0);
    branch(32'h0000_0043);
    settle();
    check("branch_pc_aligned", imem_addr, 32'h0000_0040);
    run(1'b1, 1'b1, 1'b0);
    run(1'b1, 1'b1, 1'b0);

    // PC wrap from 0xFFFFFFFC to 0
    branch(32'hFFFF_FFFC);
    run(1'b1, 1'b1, 1'b0);
    settle();
    check("pc_wrap", imem_addr, 32'h0000_0000);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, pe, bt;
      r  = ($urandom_range(0, 127) == 0);
      pe = ($urandom_range(0, 7) != 0);
      bt = ($urandom_range(0, 15) == 0);
      step(r, 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
           pe, bt, $urandom, ($urandom_range(0, 4) == 0));
    end

    // Reset while a word is held
    run(1'b1, 1'b1, 1'b0);
    run(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    settle();
    check("rst_held_instr", Instr, NOP_INSTR);
    check("rst_held_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_held_pc", imem_addr, RESET_PC);
    check("rst_held_fc", 32'(fetch_count), 32'd0);
    // The hold buffer must be gone: the next IF/ID load is the word at RESET_PC
    run(1'b1, 1'b1, 1'b0);

    // Long stall to saturate stall_count; sample only occasionally
    for (int i = 0; i < 70000; i++) begin
      chk_en = ((i % 4096) == 0) || (i == 69999);
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom),
           $urandom, 1'b0);
    end
    chk_en = 1'b1;
    settle();
    check("stall_saturated", 32'(stall_count), 32'h0000_FFFF);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
